// File: rtl/half_adder_nand_pkg.sv
// Shared arithmetic definitions for the NAND-only adder/subtractor cell.
package half_adder_nand_pkg;
   typedef enum logic [1:0] {
      MODE_HADD = 2'b00,
      MODE_FADD = 2'b01,
      MODE_HSUB = 2'b10,
      MODE_FSUB = 2'b11
   } mode_e;

   localparam int N_MODES = 4;
endpackage

// File: rtl/half_adder_nand_nand2.sv
// Two-input NAND, the single primitive every datapath function is built from.
// Purely combinational; zero latency, no flow control.
module nand2 (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = ~(x & y);
endmodule

// File: rtl/half_adder_nand.sv
// Half/full adder and subtractor built only from nand2, with a registered copy of the result.
// sum/cout are combinational; sum_q/cout_q follow one clk later; no backpressure.
module half_adder_nand
   import half_adder_nand_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [1:0] mode,
   output logic       sum,
   output logic       cout,
   output logic       sum_q,
   output logic       cout_q
);
   logic w_ab_n, w_an, w_bn, w_x;
   logic w_ha_c;
   logic w_xc_n, w_xm, w_cm, w_fs, w_fa_c;
   logic w_a_inv, w_hb_n, w_hb, w_x_inv, w_xb_n, w_fb;
   logic [1:0] w_mode_n;
   logic [N_MODES-1:0] w_dec_n, w_dec;
   logic [N_MODES-1:0] w_sum_d, w_cout_d, w_sum_t, w_cout_t;
   logic w_s01_n, w_s01, w_s23_n, w_s23;
   logic w_c01_n, w_c01, w_c23_n, w_c23;
   logic r_sum, r_cout;

   // a XOR b; w_ab_n doubles as the shared NAND(a,b) term for the carry
   nand2 u_x1 (.x(a),      .y(b),      .z(w_ab_n));
   nand2 u_x2 (.x(a),      .y(w_ab_n), .z(w_an));
   nand2 u_x3 (.x(b),      .y(w_ab_n), .z(w_bn));
   nand2 u_x4 (.x(w_an),   .y(w_bn),   .z(w_x));
   nand2 u_hc (.x(w_ab_n), .y(w_ab_n), .z(w_ha_c));

   nand2 u_f1 (.x(w_x),    .y(cin),    .z(w_xc_n));
   nand2 u_f2 (.x(w_x),    .y(w_xc_n), .z(w_xm));
   nand2 u_f3 (.x(cin),    .y(w_xc_n), .z(w_cm));
   nand2 u_f4 (.x(w_xm),   .y(w_cm),   .z(w_fs));
   nand2 u_fc (.x(w_ab_n), .y(w_xc_n), .z(w_fa_c));

   // Borrow: half = ~a & b; full adds ~(a^b) & cin
   nand2 u_b1 (.x(a),       .y(a),      .z(w_a_inv));
   nand2 u_b2 (.x(w_a_inv), .y(b),      .z(w_hb_n));
   nand2 u_b3 (.x(w_hb_n),  .y(w_hb_n), .z(w_hb));
   nand2 u_b4 (.x(w_x),     .y(w_x),    .z(w_x_inv));
   nand2 u_b5 (.x(w_x_inv), .y(cin),    .z(w_xb_n));
   nand2 u_b6 (.x(w_hb_n),  .y(w_xb_n), .z(w_fb));

   assign w_sum_d[MODE_HADD]  = w_x;
   assign w_sum_d[MODE_FADD]  = w_fs;
   assign w_sum_d[MODE_HSUB]  = w_x;
   assign w_sum_d[MODE_FSUB]  = w_fs;
   assign w_cout_d[MODE_HADD] = w_ha_c;
   assign w_cout_d[MODE_FADD] = w_fa_c;
   assign w_cout_d[MODE_HSUB] = w_hb;
   assign w_cout_d[MODE_FSUB] = w_fb;

   nand2 u_m0 (.x(mode[0]), .y(mode[0]), .z(w_mode_n[0]));
   nand2 u_m1 (.x(mode[1]), .y(mode[1]), .z(w_mode_n[1]));

   for (genvar gi = 0; gi < N_MODES; gi++) begin : g_dec
      localparam logic [1:0] SEL = 2'(gi);
      logic w_s1, w_s0;
      assign w_s1 = SEL[1] ? mode[1] : w_mode_n[1];
      assign w_s0 = SEL[0] ? mode[0] : w_mode_n[0];
      nand2 u_dn (.x(w_s1),          .y(w_s0),        .z(w_dec_n[gi]));
      nand2 u_di (.x(w_dec_n[gi]),   .y(w_dec_n[gi]), .z(w_dec[gi]));
      nand2 u_ts (.x(w_sum_d[gi]),   .y(w_dec[gi]),   .z(w_sum_t[gi]));
      nand2 u_tc (.x(w_cout_d[gi]),  .y(w_dec[gi]),   .z(w_cout_t[gi]));
   end

   // OR of the selected terms: NAND of the four inverted product terms
   nand2 u_sa (.x(w_sum_t[0]), .y(w_sum_t[1]), .z(w_s01_n));
   nand2 u_sb (.x(w_s01_n),    .y(w_s01_n),    .z(w_s01));
   nand2 u_sc (.x(w_sum_t[2]), .y(w_sum_t[3]), .z(w_s23_n));
   nand2 u_sd (.x(w_s23_n),    .y(w_s23_n),    .z(w_s23));
   nand2 u_se (.x(w_s01),      .y(w_s23),      .z(sum));

   nand2 u_ca (.x(w_cout_t[0]), .y(w_cout_t[1]), .z(w_c01_n));
   nand2 u_cb (.x(w_c01_n),     .y(w_c01_n),     .z(w_c01));
   nand2 u_cc (.x(w_cout_t[2]), .y(w_cout_t[3]), .z(w_c23_n));
   nand2 u_cd (.x(w_c23_n),     .y(w_c23_n),     .z(w_c23));
   nand2 u_ce (.x(w_c01),       .y(w_c23),       .z(cout));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= 1'b0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= sum;
         r_cout <= cout;
      end
   end

   assign sum_q  = r_sum;
   assign cout_q = r_cout;
endmodule

// File: tb/tb_half_adder_nand.sv
// Bench for half_adder_nand: directed truth-table cases, reset sequences and random traffic.
module tb_half_adder_nand;
   import half_adder_nand_pkg::*;

   logic       clk = 1'b0;
   logic       rst, a, b, cin;
   logic [1:0] mode;
   logic       sum, cout, sum_q, cout_q;
   int         n_checks = 0;
   int         n_errors = 0;

   half_adder_nand dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .mode(mode),
      .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got {result,carry}=%b expected %b", tag, got, exp);
      end
   endtask

   // Returns {sum, cout} using integer arithmetic on the operands
   function automatic logic [1:0] model(input logic ia, input logic ib, input logic ic,
                                        input logic [1:0] im);
      int c, r;
      c = (im == MODE_FADD || im == MODE_FSUB) ? int'(ic) : 0;
      if (im == MODE_HADD || im == MODE_FADD) begin
         r = int'(ia) + int'(ib) + c;
         return {1'(r % 2), 1'(r / 2)};
      end else begin
         r = int'(ia) - int'(ib) - c;
         return {1'(r & 1), r < 0};
      end
   endfunction

   // Drive at negedge, check combinational path, then check the captured value after the edge
   task automatic step(input string tag, input logic ia, input logic ib, input logic ic,
                       input logic [1:0] im, input logic ir);
      logic [1:0] exp;
      @(negedge clk);
      a = ia; b = ib; cin = ic; mode = im; rst = ir;
      exp = model(ia, ib, ic, im);
      #1;
      check_val({tag, "_comb"}, {sum, cout}, exp);
      @(posedge clk);
      #1;
      check_val({tag, "_reg"}, {sum_q, cout_q}, ir ? 2'b00 : exp);
   endtask

   initial begin
      rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0; mode = MODE_HADD;

      // Reset held for two edges
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_val("reset_q", {sum_q, cout_q}, 2'b00);
      end

      // Half add with cin=0 and cin=1, against the literal truth table
      for (int c = 0; c < 2; c++) begin
         step("hadd00", 1'b0, 1'b0, 1'(c), MODE_HADD, 1'b0);
         check_val("hadd00_lit", {sum, cout}, 2'b00);
         step("hadd01", 1'b0, 1'b1, 1'(c), MODE_HADD, 1'b0);
         check_val("hadd01_lit", {sum, cout}, 2'b10);
         step("hadd10", 1'b1, 1'b0, 1'(c), MODE_HADD, 1'b0);
         check_val("hadd10_lit", {sum, cout}, 2'b10);
         step("hadd11", 1'b1, 1'b1, 1'(c), MODE_HADD, 1'b0);
         check_val("hadd11_lit", {sum, cout}, 2'b01);
      end

      // Full add: all 8 combinations, plus the literal corner cases
      for (int v = 0; v < 8; v++)
         step("fadd", 1'(v >> 2), 1'(v >> 1), 1'(v), MODE_FADD, 1'b0);
      step("fadd111", 1'b1, 1'b1, 1'b1, MODE_FADD, 1'b0);
      check_val("fadd111_lit", {sum, cout}, 2'b11);
      step("fadd011", 1'b0, 1'b1, 1'b1, MODE_FADD, 1'b0);
      check_val("fadd011_lit", {sum, cout}, 2'b01);
      step("fadd001", 1'b0, 1'b0, 1'b1, MODE_FADD, 1'b0);
      check_val("fadd001_lit", {sum, cout}, 2'b10);

      // Subtract modes
      step("hsub01", 1'b0, 1'b1, 1'b0, MODE_HSUB, 1'b0);
      check_val("hsub01_lit", {sum, cout}, 2'b11);
      step("hsub10", 1'b1, 1'b0, 1'b1, MODE_HSUB, 1'b0);
      check_val("hsub10_lit", {sum, cout}, 2'b10);
      step("fsub001", 1'b0, 1'b0, 1'b1, MODE_FSUB, 1'b0);
      check_val("fsub001_lit", {sum, cout}, 2'b11);
      step("fsub101", 1'b1, 1'b0, 1'b1, MODE_FSUB, 1'b0);
      check_val("fsub101_lit", {sum, cout}, 2'b00);
      for (int v = 0; v < 8; v++)
         step("fsub", 1'(v >> 2), 1'(v >> 1), 1'(v), MODE_FSUB, 1'b0);

      // Registered path after reset: comb result appears before any edge
      step("regrst", 1'b0, 1'b0, 1'b0, MODE_HADD, 1'b1);
      @(negedge clk);
      rst = 1'b0; a = 1'b1; b = 1'b1; mode = MODE_HADD;
      #1;
      check_val("reg_comb_noedge", {sum, cout}, 2'b01);
      check_val("reg_q_still_reset", {sum_q, cout_q}, 2'b00);
      @(posedge clk);
      #1;
      check_val("reg_q_11", {sum_q, cout_q}, 2'b01);

      // Mid-stream reset clears registers only
      step("mid_pre", 1'b1, 1'b0, 1'b0, MODE_HADD, 1'b0);
      check_val("mid_pre_lit", {sum_q, cout_q}, 2'b10);
      step("mid_rst", 1'b1, 1'b0, 1'b0, MODE_HADD, 1'b1);
      check_val("mid_rst_lit", {sum_q, cout_q}, 2'b00);
      step("mid_post", 1'b1, 1'b0, 1'b0, MODE_HADD, 1'b0);
      check_val("mid_post_lit", {sum_q, cout_q}, 2'b10);

      // Random traffic with occasional reset
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              ($urandom_range(0, 9) == 0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/half_adder_nand.md
# half_adder_nand

Gate-level arithmetic cell built exclusively from 2-input NAND primitives. Its default mode is a half adder, and it also supports full-add, half-subtract and full-subtract modes. It exposes both the combinational NAND-network result and a registered copy for clocked consumers. It is a leaf cell used in teaching and verification of NAND-universal logic, and in ripple structures assembled at the next level up.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk.
- a  input  1  operand A (minuend in subtract modes).
- b  input  1  operand B (subtrahend in subtract modes).
- cin  input  1  carry-in (full add) or borrow-in (full subtract); ignored in half modes.
- mode  input  2  00 half add, 01 full add, 10 half subtract, 11 full subtract.
- sum  output  1  combinational sum/difference.
- cout  output  1  combinational carry-out/borrow-out.
- sum_q  output  1  sum registered on rising clk.
- cout_q  output  1  cout registered on rising clk.

## Operation
- mode 00, half add: sum = a XOR b; cout = a AND b.
- mode 01, full add: sum = a XOR b XOR cin; cout = ab OR cin(a XOR b).
- mode 10, half subtract: sum = a XOR b; cout (borrow) = NOT a AND b.
- mode 11, full subtract: sum = a XOR b XOR cin; cout (borrow) = (NOT a AND b) OR (NOT(a XOR b) AND cin).
- In half modes, cin has no effect on either output.
- Every logic function in the datapath is realised only with nand2 instances. No behavioural XOR/AND/OR/NOT operators are allowed in the datapath.
  - Inversion = NAND with both inputs tied.
  - Half adder core: 5 NAND (4 for XOR, 1 plus inverter for AND).
  - Full adder core: 9 NAND.
- Mode selection is a NAND-built 4:1 mux per output. Any X/Z on mode propagates and is not masked.

## Timing
- sum and cout are purely combinational from a, b, cin and mode. There is no clock dependency and zero cycle latency, only gate delay.
- sum_q and cout_q have 1-cycle latency: they capture sum and cout on each rising clk.
- Reset: when rst=1 at a rising edge, sum_q=0 and cout_q=0. Reset has no effect on sum/cout.
- Reset asserted mid-stream: registers clear on that edge. On the first edge with rst=0, they capture the current combinational result.
- Input changes between edges are visible immediately on sum/cout. Only the value present at the edge reaches sum_q/cout_q.
- Before the first reset, register contents are undefined.

## Structure
- Sub-module nand2 (inputs x, y; output z = NOT(x AND y)) is the only primitive. It is instantiated throughout.
- The mode encodings (MODE_HADD=2'b00, MODE_FADD=2'b01, MODE_HSUB=2'b10, MODE_FSUB=2'b11) belong in the shared arithmetic package.
- The top level contains:
  - the XOR network;
  - the carry network;
  - the borrow network;
  - the NAND mux for each output;
  - the two output flops (the only procedural logic).

## Test plan
- Half add truth table, mode=00, cin=0: a,b = 00/01/10/11 -> sum,cout = 0,0 / 1,0 / 1,0 / 0,1. Also repeat with cin=1 and confirm identical results.
- Full add, mode=01, all 8 a,b,cin combinations:
  - 111 -> sum=1, cout=1;
  - 011 -> sum=0, cout=1;
  - 001 -> sum=1, cout=0.
- Subtract, mode=10:
  - a=0, b=1 -> sum=1, cout=1;
  - a=1, b=0 -> sum=1, cout=0.
- Subtract, mode=11:
  - a=0, b=0, cin=1 -> sum=1, cout=1;
  - a=1, b=0, cin=1 -> sum=0, cout=0.
- Registered path: with rst=1 for 2 cycles, sum_q=cout_q=0. Release rst, drive a=1, b=1, mode=00. After the next rising edge, sum_q=0 and cout_q=1; sum/cout change immediately with no edge required.
- Mid-operation reset: hold a=1, b=0 (sum_q=1), then assert rst for one edge -> sum_q=0, cout_q=0. Deassert -> sum_q=1 on the following edge.
